jtag_tap_target: RTL

Fabric-side JTAG test-access-port responder, the other end of the JTAG master driven by the AXI-lite JTAG block. It oversamples TCK/TMS/TDI in the system clock domain, runs the IEEE 1149.1 16-state TAP controller, and implements the BYPASS, IDCODE and one USER data register. Its parallel port exposes the USER register to fabric logic. It is the loopback target for XVC bring-up and the debug tap for user logic.

---
 rtl/jtag_tap_pkg.sv | 37 +++
 rtl/jtag_tap_fsm.sv | 55 +++++
 rtl/jtag_tap_target.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the fabric-side JTAG TAP responder.
//   tap_state_e : 4-bit TAP controller state codes (TEST_LOGIC_RESET = 4'hF)
//   dr_sel_e    : data register selected by the active instruction
//   BypassOnes  : all-ones source for the BYPASS opcode (sliced to the IR width)
//   MaxIrWidth  : widest supported instruction register
// Optional feature macro used by the top: JTAG_TAP_IDCODE_EN.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        StExit2Dr        = 4'h0,
        StExit1Dr        = 4'h1,
        StShiftDr        = 4'h2,
        StPauseDr        = 4'h3,
        StSelectIr       = 4'h4,
        StUpdateDr       = 4'h5,
        StCaptureDr      = 4'h6,
        StSelectDr       = 4'h7,
        StExit2Ir        = 4'h8,
        StExit1Ir        = 4'h9,
        StShiftIr        = 4'hA,
        StPauseIr        = 4'hB,
        StRunTestIdle    = 4'hC,
        StUpdateIr       = 4'hD,
        StCaptureIr      = 4'hE,
        StTestLogicReset = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DrBypass = 2'd0,
        DrIdcode = 2'd1,
        DrUser   = 2'd2
    } dr_sel_e;

    localparam int unsigned MaxIrWidth = 32;
    localparam logic [MaxIrWidth-1:0] BypassOnes = '1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller, advanced once per detected TCK rise.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (state returns to TEST_LOGIC_RESET)
//   rise_i  : single-cycle TCK rising-edge strobe
//   tms_i   : TMS sampled in step with rise_i
//   state_o : current TAP state
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rise_i,
    input  logic       tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StTestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise_i) begin
            case (state_q)
                StTestLogicReset: state_d = tms_i ? StTestLogicReset : StRunTestIdle;
                StRunTestIdle:    state_d = tms_i ? StSelectDr       : StRunTestIdle;
                StSelectDr:       state_d = tms_i ? StSelectIr       : StCaptureDr;
                StCaptureDr:      state_d = tms_i ? StExit1Dr        : StShiftDr;
                StShiftDr:        state_d = tms_i ? StExit1Dr        : StShiftDr;
                StExit1Dr:        state_d = tms_i ? StUpdateDr       : StPauseDr;
                StPauseDr:        state_d = tms_i ? StExit2Dr        : StPauseDr;
                StExit2Dr:        state_d = tms_i ? StUpdateDr       : StShiftDr;
                StUpdateDr:       state_d = tms_i ? StSelectDr       : StRunTestIdle;
                StSelectIr:       state_d = tms_i ? StTestLogicReset : StCaptureIr;
                StCaptureIr:      state_d = tms_i ? StExit1Ir        : StShiftIr;
                StShiftIr:        state_d = tms_i ? StExit1Ir        : StShiftIr;
                StExit1Ir:        state_d = tms_i ? StUpdateIr       : StPauseIr;
                StPauseIr:        state_d = tms_i ? StExit2Ir        : StPauseIr;
                StExit2Ir:        state_d = tms_i ? StUpdateIr       : StShiftIr;
                StUpdateIr:       state_d = tms_i ? StSelectDr       : StRunTestIdle;
                default:          state_d = StTestLogicReset;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_target.sv
// Fabric-side JTAG TAP responder. TCK/TMS/TDI are oversampled in the s_axi_aclk
// domain; the TAP implements BYPASS, IDCODE (optional) and one USER data register
// whose captured/updated values are exposed on a parallel port.
// Optional feature: define JTAG_TAP_IDCODE_EN to build the IDCODE instruction
// (ir_o then resets to C_IDCODE_OPCODE); otherwise IDCODE decodes as BYPASS and
// ir_o resets to all-ones.
// Ports:
//   s_axi_aclk     : system clock, the only clock
//   s_axi_aresetn  : asynchronous active-low reset
//   tck_i/tms_i/tdi_i : JTAG pins, asynchronous to s_axi_aclk
//   tdo_o          : registered JTAG TDO, updated on TCK fall
//   tap_state_o    : current TAP state code
//   ir_o           : active instruction
//   user_dr_i      : value captured into USER on Capture-DR
//   user_dr_o      : value latched from USER on Update-DR
//   user_capture_o : one-cycle pulse at USER Capture-DR
//   user_update_o  : one-cycle pulse at USER Update-DR
module jtag_tap_target
    import jtag_tap_pkg::*;
#(
    parameter int unsigned           C_IR_WIDTH      = 4,
    parameter int unsigned           C_DR_WIDTH      = 32,
    parameter logic [31:0]           C_IDCODE        = 32'h0372_2093,
    parameter logic [C_IR_WIDTH-1:0] C_IDCODE_OPCODE = C_IR_WIDTH'(1),
    parameter logic [C_IR_WIDTH-1:0] C_USER_OPCODE   = C_IR_WIDTH'(2)
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  tck_i,
    input  logic                  tms_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    output logic [3:0]            tap_state_o,
    output logic [C_IR_WIDTH-1:0] ir_o,
    input  logic [C_DR_WIDTH-1:0] user_dr_i,
    output logic [C_DR_WIDTH-1:0] user_dr_o,
    output logic                  user_capture_o,
    output logic                  user_update_o
);

    localparam logic [C_IR_WIDTH-1:0] IrBypass  = BypassOnes[C_IR_WIDTH-1:0];
    localparam logic [C_IR_WIDTH-1:0] IrCapture = {{(C_IR_WIDTH-1){1'b0}}, 1'b1};
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [C_IR_WIDTH-1:0] IrReset   = C_IDCODE_OPCODE;
`else
    localparam logic [C_IR_WIDTH-1:0] IrReset   = IrBypass;
`endif

    // Elaboration-time parameter sanity.
    if (C_IR_WIDTH < 2 || C_IR_WIDTH > MaxIrWidth) begin : g_bad_ir_width
        $error("jtag_tap_target: C_IR_WIDTH out of range");
    end
    if (C_IDCODE[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_target: IDCODE LSB must be 1");
    end
    if (C_IDCODE_OPCODE == C_USER_OPCODE || C_USER_OPCODE == IrBypass) begin : g_bad_opcode
        $error("jtag_tap_target: USER opcode collides with another instruction");
    end

    // ---------------------------------------------------------------------
    // Pin synchronizers; the extra TCK stage provides edge detection.
    // ---------------------------------------------------------------------
    logic tck_s1_q, tck_s2_q, tck_s3_q;
    logic tms_s1_q, tms_s2_q;
    logic tdi_s1_q, tdi_s2_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tck_s1_q <= 1'b0;
            tck_s2_q <= 1'b0;
            tck_s3_q <= 1'b0;
            tms_s1_q <= 1'b0;
            tms_s2_q <= 1'b0;
            tdi_s1_q <= 1'b0;
            tdi_s2_q <= 1'b0;
        end else begin
            tck_s1_q <= tck_i;
            tck_s2_q <= tck_s1_q;
            tck_s3_q <= tck_s2_q;
            tms_s1_q <= tms_i;
            tms_s2_q <= tms_s1_q;
            tdi_s1_q <= tdi_i;
            tdi_s2_q <= tdi_s1_q;
        end
    end

    logic tck_rise, tck_fall;
    assign tck_rise = tck_s2_q & ~tck_s3_q;
    assign tck_fall = ~tck_s2_q & tck_s3_q;

    // ---------------------------------------------------------------------
    // TAP controller
    // ---------------------------------------------------------------------
    tap_state_e state;

    jtag_tap_fsm u_fsm (
        .clk_i   (s_axi_aclk),
        .rst_ni  (s_axi_aresetn),
        .rise_i  (tck_rise),
        .tms_i   (tms_s2_q),
        .state_o (state)
    );

    // ---------------------------------------------------------------------
    // Instruction decode
    // ---------------------------------------------------------------------
    logic [C_IR_WIDTH-1:0] ir_q, ir_d;
    dr_sel_e               dr_sel;

    always_comb begin
        dr_sel = DrBypass;
        if (ir_q == IrBypass) begin
            dr_sel = DrBypass;
`ifdef JTAG_TAP_IDCODE_EN
        end else if (ir_q == C_IDCODE_OPCODE) begin
            dr_sel = DrIdcode;
`endif
        end else if (ir_q == C_USER_OPCODE) begin
            dr_sel = DrUser;
        end
    end

    // ---------------------------------------------------------------------
    // Shift/update registers
    // ---------------------------------------------------------------------
    logic [C_IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic                  bypass_q, bypass_d;
    logic [C_DR_WIDTH-1:0] user_shift_q, user_shift_d, user_shifted;
    logic [C_DR_WIDTH-1:0] user_dr_q, user_dr_d;
    logic                  tdo_q, tdo_d;
    logic                  capture_q, capture_d;
    logic                  update_q, update_d;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0]           idcode_shift_q, idcode_shift_d;
`endif

    // A 1-bit USER register has no upper slice to shift down.
    if (C_DR_WIDTH == 1) begin : g_user_dr1
        assign user_shifted = tdi_s2_q;
    end else begin : g_user_drn
        assign user_shifted = {tdi_s2_q, user_shift_q[C_DR_WIDTH-1:1]};
    end

    always_comb begin
        ir_shift_d   = ir_shift_q;
        ir_d         = ir_q;
        bypass_d     = bypass_q;
        user_shift_d = user_shift_q;
        user_dr_d    = user_dr_q;
        tdo_d        = tdo_q;
        capture_d    = 1'b0;
        update_d     = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        idcode_shift_d = idcode_shift_q;
`endif

        if (tck_rise) begin
            case (state)
                StCaptureIr: ir_shift_d = IrCapture;
                StShiftIr:   ir_shift_d = {tdi_s2_q, ir_shift_q[C_IR_WIDTH-1:1]};
                StCaptureDr: begin
                    case (dr_sel)
`ifdef JTAG_TAP_IDCODE_EN
                        DrIdcode: idcode_shift_d = C_IDCODE;
`endif
                        DrUser: begin
                            user_shift_d = user_dr_i;
                            capture_d    = 1'b1;
                        end
                        default: bypass_d = 1'b0;
                    endcase
                end
                StShiftDr: begin
                    case (dr_sel)
`ifdef JTAG_TAP_IDCODE_EN
                        DrIdcode: idcode_shift_d = {tdi_s2_q, idcode_shift_q[31:1]};
`endif
                        DrUser:   user_shift_d = user_shifted;
                        default:  bypass_d = tdi_s2_q;
                    endcase
                end
                default: ;
            endcase
        end

        if (tck_fall) begin
            tdo_d = 1'b0;
            case (state)
                StShiftIr: tdo_d = ir_shift_q[0];
                StShiftDr: begin
                    case (dr_sel)
`ifdef JTAG_TAP_IDCODE_EN
                        DrIdcode: tdo_d = idcode_shift_q[0];
`endif
                        DrUser:   tdo_d = user_shift_q[0];
                        default:  tdo_d = bypass_q;
                    endcase
                end
                StUpdateIr: ir_d = ir_shift_q;
                StUpdateDr: begin
                    if (dr_sel == DrUser) begin
                        user_dr_d = user_shift_q;
                        update_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Held in reset while the TAP sits in TEST_LOGIC_RESET; user_dr is kept.
        if (state == StTestLogicReset) begin
            ir_d = IrReset;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ir_shift_q   <= '0;
            ir_q         <= IrReset;
            bypass_q     <= 1'b0;
            user_shift_q <= '0;
            user_dr_q    <= '0;
            tdo_q        <= 1'b0;
            capture_q    <= 1'b0;
            update_q     <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_shift_q <= '0;
`endif
        end else begin
            ir_shift_q   <= ir_shift_d;
            ir_q         <= ir_d;
            bypass_q     <= bypass_d;
            user_shift_q <= user_shift_d;
            user_dr_q    <= user_dr_d;
            tdo_q        <= tdo_d;
            capture_q    <= capture_d;
            update_q     <= update_d;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_shift_q <= idcode_shift_d;
`endif
        end
    end

    assign tdo_o          = tdo_q;
    assign tap_state_o    = state;
    assign ir_o           = ir_q;
    assign user_dr_o      = user_dr_q;
    assign user_capture_o = capture_q;
    assign user_update_o  = update_q;

endmodule
